// File: rtl/square_root_arbiter.sv
// Round-robin arbiter that shares one square-root unit among NUM_REQ requesters,
// with a per-transaction timeout that reports an error result.

`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef LONG_WIDTH
`define LONG_WIDTH 64
`endif
`ifndef SCALE
`define SCALE 17
`endif

// state | meaning
// IDLE  | waiting for any request; round-robin pick from the pointer
// ISSUE | grant pulse to the winner, start strobe to the unit
// WAIT  | waiting for the unit result or the timeout
// DONE  | done pulse with result/error, pointer moves past the winner
module square_root_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [NUM_REQ-1:0]              iRequest,
  input  logic [NUM_REQ*`LONG_WIDTH-1:0]  iOperands,
  output logic [NUM_REQ-1:0]              oGrant,
  output logic [NUM_REQ-1:0]              oDone,
  output logic [`WIDTH-1:0]               oResult,
  output logic                            oError,
  output logic                            oBusy,
  output logic [`LONG_WIDTH-1:0]          oSqrtOperand,
  output logic                            oSqrtInputReady,
  input  logic                            iSqrtOutputReady,
  input  logic [`WIDTH-1:0]               iSqrtResult
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW = `LONG_WIDTH;
  localparam int W = `WIDTH;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [LW-1:0]    operand_q, operand_d;
  logic             err_q, err_d;
  logic [W-1:0]     result_q, result_d;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan downward so the closest requester at or above the pointer is written last.
  always_comb begin
    sel_idx   = ptr_q;
    sel_found = |iRequest;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (iRequest[rot_idx(ptr_q, k)]) sel_idx = rot_idx(ptr_q, k);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    err_d     = err_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          winner_d  = sel_idx;
          operand_d = iOperands[int'(sel_idx)*LW +: LW];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (iSqrtOutputReady) begin
          result_d = iSqrtResult;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        ptr_d   = (winner_q == IDX_LAST) ? '0 : winner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      winner_q  <= '0;
      cnt_q     <= '0;
      operand_q <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      err_q     <= err_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    oGrant = '0;
    oDone  = '0;
    if (state_q == S_ISSUE) oGrant[winner_q] = 1'b1;
    if (state_q == S_DONE) oDone[winner_q] = 1'b1;
  end

  assign oSqrtInputReady = (state_q == S_ISSUE);
  assign oError          = (state_q == S_DONE) & err_q;
  assign oBusy           = (state_q != S_IDLE);
  assign oSqrtOperand    = operand_q;
  assign oResult         = result_q;

endmodule

// File: tb/tb_square_root_arbiter.sv
// Bench for square_root_arbiter: a timestamp-based transaction model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.

`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef LONG_WIDTH
`define LONG_WIDTH 64
`endif
`ifndef SCALE
`define SCALE 17
`endif

module tb_square_root_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;
  localparam int LW = `LONG_WIDTH;
  localparam int W = `WIDTH;

  logic                     Clock = 1'b0;
  logic                     Reset = 1'b1;
  logic [NUM_REQ-1:0]       iRequest = '0;
  logic [NUM_REQ*LW-1:0]    iOperands = '0;
  logic [NUM_REQ-1:0]       oGrant, oDone;
  logic [W-1:0]             oResult;
  logic                     oError, oBusy;
  logic [LW-1:0]            oSqrtOperand;
  logic                     oSqrtInputReady;
  logic                     iSqrtOutputReady = 1'b0;
  logic [W-1:0]             iSqrtResult = '0;

  square_root_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .iRequest(iRequest), .iOperands(iOperands),
    .oGrant(oGrant), .oDone(oDone), .oResult(oResult), .oError(oError), .oBusy(oBusy),
    .oSqrtOperand(oSqrtOperand), .oSqrtInputReady(oSqrtInputReady),
    .iSqrtOutputReady(iSqrtOutputReady), .iSqrtResult(iSqrtResult)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // Transaction model: one transaction at a time, described by the cycle it was
  // issued and the cycle its completion is reported.
  longint        cyc = 0;
  bit            m_active = 0;
  longint        m_issue = -100;
  longint        m_done = -100;
  bit            m_have_done = 0;
  int            m_winner = 0;
  int            m_ptr = 0;
  logic [LW-1:0] m_operand = '0;
  logic [W-1:0]  m_result = '0;
  bit            m_err = 0;

  function automatic void model_step();
    longint prev;
    bit found;
    prev = cyc;
    cyc = cyc + 1;
    found = 0;
    if (Reset) begin
      m_active = 0; m_ptr = 0; m_winner = 0; m_operand = '0;
      m_result = '0; m_err = 0; m_have_done = 0;
    end else if (m_active && m_have_done && prev == m_done) begin
      m_active = 0;
      m_ptr = (m_winner + 1) % NUM_REQ;
    end else if (!m_active) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (!found && iRequest[idx]) begin
          found = 1;
          m_winner = idx;
        end
      end
      if (found) begin
        m_active = 1;
        m_issue = cyc;
        m_have_done = 0;
        m_operand = iOperands[m_winner*LW +: LW];
      end
    end else if (!m_have_done && prev > m_issue) begin
      if (iSqrtOutputReady) begin
        m_have_done = 1; m_done = cyc; m_result = iSqrtResult; m_err = 0;
      end else if (prev == m_issue + TIMEOUT) begin
        m_have_done = 1; m_done = cyc; m_result = '0; m_err = 1;
      end
    end
  endfunction

  always @(posedge Clock) model_step();

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    logic [NUM_REQ-1:0] eg, ed;
    eg = (m_active && cyc == m_issue) ? onehot(m_winner) : '0;
    ed = (m_active && m_have_done && cyc == m_done) ? onehot(m_winner) : '0;
    chk("oGrant", 64'(oGrant), 64'(eg));
    chk("oSqrtInputReady", 64'(oSqrtInputReady), 64'(|eg));
    chk("oDone", 64'(oDone), 64'(ed));
    chk("oBusy", 64'(oBusy), 64'(m_active));
    chk("oResult", 64'(oResult), 64'(m_result));
    chk("oSqrtOperand", 64'(oSqrtOperand), 64'(m_operand));
    if (ed != '0) chk("oError", 64'(oError), 64'(m_err));
  endtask

  // Stub unit and requester behaviour, advanced once per cycle at the falling edge.
  int           stub_cnt = 0;
  int           stub_lat = 1;
  bit           stub_rand = 0;
  bit           spur_en = 0;
  logic [W-1:0] stub_val = '0;
  int           req_mode = 0;  // 0 hold, 1 drop on grant, 2 random traffic
  bit           chk_en = 0;
  longint       ntick = 0;
  int           done_log[$];
  longint       done_tick[$];

  function automatic logic [LW-1:0] rand_op();
    return LW'({$urandom, $urandom});
  endfunction

  task automatic tick();
    int lat;
    @(negedge Clock);
    ntick++;
    if (chk_en) compare_all();
    for (int i = 0; i < NUM_REQ; i++)
      if (oDone[i]) begin
        done_log.push_back(i);
        done_tick.push_back(ntick);
      end
    iSqrtOutputReady = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        iSqrtOutputReady = 1'b1;
        iSqrtResult = stub_rand ? W'($urandom) : stub_val;
      end
    end else if (spur_en && $urandom_range(0, 9) == 0) begin
      iSqrtOutputReady = 1'b1;
      iSqrtResult = W'($urandom);
    end
    if (oSqrtInputReady) begin
      if (stub_rand) lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
      else lat = stub_lat;
      stub_cnt = lat;
    end
    if (req_mode == 1) begin
      for (int i = 0; i < NUM_REQ; i++) if (oGrant[i]) iRequest[i] = 1'b0;
    end else if (req_mode == 2) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (oGrant[i]) begin
          if ($urandom_range(0, 1) == 1) iRequest[i] = 1'b0;
          iOperands[i*LW +: LW] = rand_op();
        end else if (!iRequest[i]) begin
          iOperands[i*LW +: LW] = rand_op();
          if ($urandom_range(0, 3) == 0) iRequest[i] = 1'b1;
        end
      end
      Reset = ($urandom_range(0, 199) == 0);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      if (oDone != '0) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_done: got no oDone, expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_grant(input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      if (oGrant != '0) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_grant: got no oGrant, expected one within %0d cycles", budget);
    end
  endtask

  task automatic collect(input int want, input int budget);
    for (int n = 0; n < budget && done_log.size() < want; n++) tick();
    if (done_log.size() < want) begin
      checks++; errors++;
      $display("FAIL collect: got %0d completions, expected %0d", done_log.size(), want);
    end
  endtask

  initial begin
    longint g;
    int exp_rr[4];
    exp_rr = '{1, 3, 1, 3};

    tick();
    chk_en = 1;
    do_reset();
    chk("reset busy", 64'(oBusy), 64'd0);
    chk("reset result", 64'(oResult), 64'd0);

    // Single request, 1-cycle unit
    req_mode = 1; stub_rand = 0; stub_lat = 1; stub_val = 32'h40000; spur_en = 0;
    iOperands = '0;
    iOperands[2*LW +: LW] = 64'h80000;
    iRequest = 4'b0100;
    tick();
    chk("single grant", 64'(oGrant), 64'b0100);
    chk("single strobe", 64'(oSqrtInputReady), 64'd1);
    chk("single operand", 64'(oSqrtOperand), 64'h80000);
    iOperands[2*LW +: LW] = 64'hDEAD;
    tick();
    chk("single no early done", 64'(oDone), 64'd0);
    tick();
    chk("single done", 64'(oDone), 64'b0100);
    chk("single result", 64'(oResult), 64'h40000);
    chk("single error", 64'(oError), 64'd0);
    chk("single operand held", 64'(oSqrtOperand), 64'h80000);

    // All four held high from reset release
    Reset = 1'b1; req_mode = 0; iRequest = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) iOperands[i*LW +: LW] = rand_op();
    tick(); tick();
    done_log.delete(); done_tick.delete();
    Reset = 1'b0;
    collect(12, 200);
    for (int i = 0; i < 12 && i < done_log.size(); i++)
      chk($sformatf("all4 order[%0d]", i), 64'(done_log[i]), 64'(i % 4));
    for (int i = 1; i < 12 && i < done_tick.size(); i++)
      chk($sformatf("all4 spacing[%0d]", i), 64'(done_tick[i] - done_tick[i-1]), 64'd4);

    // Requesters 1 and 3 alternate
    Reset = 1'b1; iRequest = 4'b1010;
    tick(); tick();
    done_log.delete(); done_tick.delete();
    Reset = 1'b0;
    collect(4, 100);
    for (int i = 0; i < 4 && i < done_log.size(); i++)
      chk($sformatf("alt order[%0d]", i), 64'(done_log[i]), 64'(exp_rr[i]));

    // Timeout, then a normal transaction
    iRequest = '0;
    do_reset();
    req_mode = 1; stub_lat = 0;
    iRequest = 4'b0010;
    wait_grant(10);
    g = ntick;
    wait_done(30);
    chk("timeout latency", 64'(ntick - g), 64'd9);
    chk("timeout error", 64'(oError), 64'd1);
    chk("timeout result", 64'(oResult), 64'd0);
    chk("timeout done", 64'(oDone), 64'b0010);
    stub_lat = 1; stub_val = 32'h2A000;
    iRequest = 4'b0001;
    wait_done(20);
    chk("after timeout done", 64'(oDone), 64'b0001);
    chk("after timeout error", 64'(oError), 64'd0);
    chk("after timeout result", 64'(oResult), 64'h2A000);

    // Reset while waiting, result arrives just after
    do_reset();
    req_mode = 1; stub_lat = 2; stub_val = 32'h11111;
    iRequest = 4'b0001;
    tick();
    chk("midreset grant", 64'(oGrant), 64'b0001);
    tick();
    chk("midreset busy in wait", 64'(oBusy), 64'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midreset no done", 64'(oDone), 64'd0);
      chk("midreset result", 64'(oResult), 64'd0);
      chk("midreset busy", 64'(oBusy), 64'd0);
    end
    iRequest = 4'b0011;
    tick();
    chk("midreset next grant", 64'(oGrant), 64'b0001);
    wait_done(20);
    chk("midreset first done", 64'(oDone), 64'b0001);
    wait_done(20);
    chk("midreset second done", 64'(oDone), 64'b0010);
    chk("midreset result ok", 64'(oResult), 64'h11111);

    // Spurious strobe while idle
    tick();
    iSqrtOutputReady = 1'b1;
    iSqrtResult = 32'h12345;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("spurious result", 64'(oResult), 64'h11111);
      chk("spurious done", 64'(oDone), 64'd0);
    end

    // Randomized traffic
    stub_rand = 1; spur_en = 1; req_mode = 2;
    repeat (4000) tick();
    req_mode = 0; Reset = 1'b0; spur_en = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/square_root_arbiter.md
SQUARE_ROOT_ARBITER -- requirements
Module: square_root_arbiter

Interface
REQ-001 The block SHALL have one clock, Clock, and a synchronous, active-high reset, Reset.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requester ports; legal values are 2 to 8.
REQ-003 Parameter TIMEOUT, default 8, SHALL set the maximum number of WAIT cycles before a transaction is aborted; legal values are 2 to 255.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- iRequest  in  NUM_REQ  per-requester request level.
- iOperands  in  NUM_REQ*`LONG_WIDTH  packed operands; requester i occupies slice [i*`LONG_WIDTH +: `LONG_WIDTH].
- oGrant  out  NUM_REQ  one-hot, one-cycle pulse: the operand has been captured.
- oDone  out  NUM_REQ  one-hot, one-cycle pulse: oResult and oError are valid for that requester.
- oResult  out  `WIDTH  square-root result in fixed point, `SCALE fraction bits.
- oError  out  1  timeout flag; valid only while an oDone bit is high.
- oBusy  out  1  high when the FSM is not in IDLE.
- oSqrtOperand  out  `LONG_WIDTH  operand to the shared square-root unit.
- oSqrtInputReady  out  1  one-cycle start strobe to the unit.
- iSqrtOutputReady  in  1  result-valid strobe from the unit.
- iSqrtResult  in  `WIDTH  result from the unit.

Function
REQ-005 The FSM SHALL have four states, IDLE, ISSUE, WAIT and DONE, with registered state.
REQ-006 In IDLE with any iRequest bit high, the block SHALL select the first requester at or above the priority pointer, searching upward modulo NUM_REQ.
REQ-007 On that selection, the block SHALL latch the winner index and its operand, and go to ISSUE; in IDLE with no request, it SHALL stay in IDLE.
REQ-008 In ISSUE, oGrant[winner] and oSqrtInputReady SHALL both be 1 for exactly one cycle, and the state SHALL then go to WAIT with the timeout counter cleared to 0.
REQ-009 oSqrtOperand SHALL always equal the latched operand register.
REQ-010 In WAIT with iSqrtOutputReady=1, the block SHALL register iSqrtResult into oResult, clear the error flag, and go to DONE.
REQ-011 In WAIT with iSqrtOutputReady=0, the counter SHALL increment.
REQ-012 If the counter equals TIMEOUT-1 with iSqrtOutputReady=0, the block SHALL load oResult=0, set the error flag to 1, and go to DONE.
REQ-013 If iSqrtOutputReady=1 in the same cycle as the counter expiry, the result SHALL take precedence over the timeout.
REQ-014 In DONE, oDone[winner]=1 and oError=error flag SHALL hold for one cycle; the priority pointer SHALL become (winner+1) mod NUM_REQ, and the state SHALL return to IDLE.
REQ-015 iSqrtOutputReady outside WAIT SHALL be ignored, and oResult SHALL be left unchanged.
REQ-016 oResult SHALL hold its last value between completions.
REQ-017 Latency: for a request sampled in IDLE at cycle t with a 1-cycle unit, oGrant and the strobe SHALL occur at t+1 and oDone at t+3; peak throughput SHALL be one operation per 4 cycles.
REQ-018 Requesters SHALL hold iRequest and the operand until oGrant.
REQ-019 A request still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-020 The iOperands value at the selection cycle SHALL be the one used for the transaction; later changes SHALL have no effect on it.
REQ-021 oBusy SHALL be combinationally derived from the state; all other outputs SHALL be registered or decoded only from the state and latched index.

Reset
REQ-022 While Reset=1 at a rising edge, the block SHALL set: state=IDLE, pointer=0, counter=0, winner=0, operand register=0, error flag=0, oResult=0.
REQ-023 Reset SHALL drive oGrant, oDone, oSqrtInputReady, oError and oBusy to 0 in the cycle after the reset edge.
REQ-024 Reset asserted in any state SHALL abort the transaction in flight, with no oDone for it; a unit result that arrives afterwards SHALL be ignored.

Verification
REQ-025 Single request, with a 1-cycle stub unit returning iSqrtResult=0x40000:
- Stimulus: requester 2 at cycle t, operand = 4.0 (0x80000).
- Required response: oGrant=4'b0100 at t+1; oSqrtOperand=0x80000 with strobe at t+1; oDone=4'b0100 at t+3; oResult=0x40000; oError=0.
REQ-026 All four requesters held high from reset release:
- Required response: oDone order 0,1,2,3; after the fifth grant goes to requester 0 (pointer wrap), the third round again starts at 0.
REQ-027 Round-robin alternation:
- Stimulus: requesters 1 and 3 held high continuously.
- Required response: service alternates 1,3,1,3; requester 1 never gets two consecutive grants.
REQ-028 Timeout:
- Stimulus: stub never asserts iSqrtOutputReady; TIMEOUT=8.
- Required response: oDone arrives 8 cycles after entering WAIT, with oError=1 and oResult=0; the next request is then served normally.
REQ-029 Reset mid-operation:
- Stimulus: Reset during WAIT, while the stub returns a result one cycle later.
- Required response: no oDone; oResult=0; oBusy=0; the next request from requesters 0 and 1 together is granted to 0.
REQ-030 Spurious result strobe:
- Stimulus: iSqrtOutputReady=1 with iSqrtResult=0x12345 while in IDLE.
- Required response: oResult unchanged; no oDone.
